// File: rtl/irrigation_pkg.sv
// Shared codes and constants for the irrigation scheduler slice.
// State, irrigation-command and arbiter encodings plus the timer width.
package irrigation_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    ST_E = 2'b00,
    ST_A = 2'b01,
    ST_G = 2'b10,
    ST_L = 2'b11
  } fsm_state_t;

  typedef enum logic [1:0] {
    IRR_NO = 2'b00,
    IRR_AS = 2'b01,
    IRR_GS = 2'b10,
    IRR_SP = 2'b11
  } irr_code_t;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // A zero dwell would never expire, so it is promoted to one tick.
  function automatic logic [TMR_W-1:0] dur_clip(input int dur);
    if (dur < 1) return TMR_W'(1);
    return TMR_W'(dur);
  endfunction

endpackage

// File: rtl/state_timer.sv
// Dwell timer for the main FSM: prescaler, tick counter and done flag.
// Emits a single time_over pulse per state visit.
module state_timer
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int DUR_E    = 2,
  parameter int DUR_A    = 3,
  parameter int DUR_G    = 5,
  parameter int DUR_L    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] state,
  output logic [1:0] state_q,
  output logic       time_over
);

  localparam logic [TMR_W-1:0] PRESC_LAST = TMR_W'(TICK_DIV - 1);

  logic [TMR_W-1:0] presc_reg, presc_next, cnt_reg, cnt_next;
  logic [TMR_W-1:0] presc_eff, cnt_eff, dur_last;
  logic             done_reg, done_next, done_eff;
  logic [1:0]       state_reg;
  logic             entry, tick, expire;

  always_comb begin
    // The entry cycle behaves as if the timer had already been cleared.
    entry     = (state != state_reg);
    presc_eff = entry ? '0 : presc_reg;
    cnt_eff   = entry ? '0 : cnt_reg;
    done_eff  = entry ? 1'b0 : done_reg;

    case (fsm_state_t'(state))
      ST_E:    dur_last = dur_clip(DUR_E) - TMR_W'(1);
      ST_A:    dur_last = dur_clip(DUR_A) - TMR_W'(1);
      ST_G:    dur_last = dur_clip(DUR_G) - TMR_W'(1);
      default: dur_last = dur_clip(DUR_L) - TMR_W'(1);
    endcase

    tick       = (presc_eff == PRESC_LAST);
    expire     = tick && (cnt_eff == dur_last) && !done_eff;
    presc_next = tick ? '0 : presc_eff + TMR_W'(1);
    cnt_next   = (tick && !done_eff && !expire) ? cnt_eff + TMR_W'(1) : cnt_eff;
    done_next  = done_eff | expire;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      state_reg <= ST_E;
    end else begin
      presc_reg <= presc_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      state_reg <= state;
    end
  end

  assign state_q   = state_reg;
  assign time_over = expire & reset_n;

endmodule

// File: rtl/irrigation_scheduler.sv
// Zone arbiter and valve/pump decode around the dwell timer.
// Grants are latched in E and released on the L->E transition.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int DUR_E    = 2,
  parameter int DUR_A    = 3,
  parameter int DUR_G    = 5,
  parameter int DUR_L    = 2,
  parameter int MERGE    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] state,
  input  logic       req_asp,
  input  logic       req_drip,
  output logic [1:0] irrigation,
  output logic       time_over,
  output logic       valve_asp,
  output logic       valve_drip,
  output logic       pump_on
);

  arb_state_t arb_reg, arb_next;
  logic [1:0] grant_reg, grant_next;
  logic       ptr_reg, ptr_next;  // 0 = aspersion next, 1 = drip next
  logic [1:0] state_q;
  logic       release_cyc;

  state_timer #(
    .TICK_DIV (TICK_DIV),
    .DUR_E    (DUR_E),
    .DUR_A    (DUR_A),
    .DUR_G    (DUR_G),
    .DUR_L    (DUR_L)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .state     (state),
    .state_q   (state_q),
    .time_over (time_over)
  );

  always_comb begin
    arb_next    = arb_reg;
    grant_next  = grant_reg;
    ptr_next    = ptr_reg;
    release_cyc = (state_q == ST_L) && (state == ST_E);
    case (arb_reg)
      ARB_IDLE: begin
        if ((state == ST_E) && (req_asp || req_drip)) begin
          arb_next = ARB_GRANTED;
          if (req_asp && req_drip)
            grant_next = (MERGE != 0) ? IRR_SP : (ptr_reg ? IRR_GS : IRR_AS);
          else
            grant_next = req_asp ? IRR_AS : IRR_GS;
        end
      end
      default: begin
        if (release_cyc) begin
          arb_next   = ARB_IDLE;
          grant_next = IRR_NO;
          // A merged grant served both zones, so fairness is unaffected.
          if (grant_reg == IRR_AS)      ptr_next = 1'b1;
          else if (grant_reg == IRR_GS) ptr_next = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arb_reg   <= ARB_IDLE;
      grant_reg <= IRR_NO;
      ptr_reg   <= 1'b0;
    end else begin
      arb_reg   <= arb_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Outputs are forced low while reset is held, regardless of state.
  assign irrigation = grant_reg;
  assign pump_on    = reset_n & ((state == ST_A) || (state == ST_G));
  assign valve_asp  = reset_n & (state == ST_G) & grant_reg[0];
  assign valve_drip = reset_n & (state == ST_G) & grant_reg[1];

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: one merging and one round-robin
// instance share stimulus; expected values are hand-computed constants.
module tb_irrigation_scheduler;

  localparam logic [1:0] E = 2'b00, A = 2'b01, G = 2'b10, L = 2'b11;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] state;
  logic       req_asp, req_drip;

  logic [1:0] m_irr, r_irr;
  logic       m_to, m_va, m_vd, m_pump;
  logic       r_to, r_va, r_vd, r_pump;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  irrigation_scheduler #(.MERGE(1)) u_dut_m (
    .clock      (clock),
    .reset_n    (reset_n),
    .state      (state),
    .req_asp    (req_asp),
    .req_drip   (req_drip),
    .irrigation (m_irr),
    .time_over  (m_to),
    .valve_asp  (m_va),
    .valve_drip (m_vd),
    .pump_on    (m_pump)
  );

  irrigation_scheduler #(.MERGE(0)) u_dut_r (
    .clock      (clock),
    .reset_n    (reset_n),
    .state      (state),
    .req_asp    (req_asp),
    .req_drip   (req_drip),
    .irrigation (r_irr),
    .time_over  (r_to),
    .valve_asp  (r_va),
    .valve_drip (r_vd),
    .pump_on    (r_pump)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic ra, input logic rd);
    state    = st;
    req_asp  = ra;
    req_drip = rd;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // One E->A->G->L->E irrigation round with the given requests.
  task automatic full_cycle(input logic ra, input logic rd,
                            input logic [1:0] exp_m, input logic [1:0] exp_r);
    drive(E, ra, rd);
    check_eq("fc_idle_m", m_irr, 2'b00);
    check_eq("fc_idle_r", r_irr, 2'b00);
    next_cycle();
    drive(A, 1'b0, 1'b0);
    check_eq("fc_grant_m", m_irr, exp_m);
    check_eq("fc_grant_r", r_irr, exp_r);
    check_eq("fc_pump_a", m_pump, 1'b1);
    check_eq("fc_va_a", m_va, 1'b0);
    next_cycle();
    drive(G, 1'b0, 1'b0);
    check_eq("fc_va_g_m", m_va, exp_m[0]);
    check_eq("fc_vd_g_m", m_vd, exp_m[1]);
    check_eq("fc_va_g_r", r_va, exp_r[0]);
    check_eq("fc_vd_g_r", r_vd, exp_r[1]);
    check_eq("fc_pump_g", r_pump, 1'b1);
    next_cycle();
    drive(L, 1'b0, 1'b0);
    check_eq("fc_pump_l", m_pump, 1'b0);
    check_eq("fc_va_l", m_va | m_vd, 1'b0);
    check_eq("fc_hold_l", m_irr, exp_m);
    next_cycle();
    drive(E, 1'b0, 1'b0);
    check_eq("fc_rel_cyc", r_irr, exp_r);
    next_cycle();
    drive(E, 1'b0, 1'b0);
    check_eq("fc_released_m", m_irr, 2'b00);
    check_eq("fc_released_r", r_irr, 2'b00);
    next_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    state = A; req_asp = 1'b0; req_drip = 1'b0;
    #2;
    check_eq("rst_irr", m_irr, 2'b00);
    check_eq("rst_to", m_to, 1'b0);
    check_eq("rst_pump", m_pump, 1'b0);
    check_eq("rst_valves", m_va | m_vd | r_va | r_vd, 1'b0);
    state = E;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();

    // Dwell in A: single pulse at cycle 11 of the visit.
    for (int c = 0; c < 20; c++) begin
      drive(A, 1'b0, 1'b0);
      check_eq($sformatf("dwell_a_c%0d", c), m_to, (c == 11));
      next_cycle();
    end

    // Rounds: aspersion; both twice (merge vs round robin); drip only.
    full_cycle(1'b1, 1'b0, 2'b01, 2'b01);
    full_cycle(1'b1, 1'b1, 2'b11, 2'b10);
    full_cycle(1'b1, 1'b1, 2'b11, 2'b01);
    full_cycle(1'b0, 1'b1, 2'b10, 2'b10);

    // Requests outside E while idle are ignored.
    for (int c = 0; c < 3; c++) begin
      drive(A, 1'b0, 1'b1);
      next_cycle();
      check_eq($sformatf("ign_a_c%0d", c), m_irr, 2'b00);
    end

    // Idle E with no grant: one pulse per entry, at cycle 7.
    for (int c = 0; c < 14; c++) begin
      drive(E, 1'b0, 1'b0);
      check_eq($sformatf("dwell_e_c%0d", c), m_to, (c == 7));
      next_cycle();
    end

    // G abandoned at cycle 10: no G pulse, L pulse at cycle 7.
    for (int c = 0; c < 2; c++) begin
      drive(A, 1'b0, 1'b0);
      next_cycle();
    end
    for (int c = 0; c < 10; c++) begin
      drive(G, 1'b0, 1'b0);
      check_eq($sformatf("g_short_c%0d", c), m_to, 1'b0);
      next_cycle();
    end
    for (int c = 0; c < 10; c++) begin
      drive(L, 1'b0, 1'b0);
      check_eq($sformatf("l_after_g_c%0d", c), m_to, (c == 7));
      next_cycle();
    end
    drive(E, 1'b0, 1'b0);
    next_cycle();

    // Reset while granted at a pending tick.
    drive(E, 1'b1, 1'b0);
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(G, 1'b0, 1'b0);
      next_cycle();
    end
    drive(G, 1'b0, 1'b0);
    check_eq("pre_rst_va", m_va, 1'b1);
    check_eq("pre_rst_irr", m_irr, 2'b01);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_irr_m", m_irr, 2'b00);
    check_eq("mid_rst_irr_r", r_irr, 2'b00);
    check_eq("mid_rst_to", m_to, 1'b0);
    check_eq("mid_rst_va", m_va, 1'b0);
    check_eq("mid_rst_pump", m_pump, 1'b0);
    #2;
    reset_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(A, 1'b1, 1'b0);
      next_cycle();
      check_eq($sformatf("post_rst_a_c%0d", c), m_irr, 2'b00);
    end
    drive(E, 1'b1, 1'b0);
    check_eq("post_rst_e_same", m_irr, 2'b00);
    next_cycle();
    check_eq("post_rst_grant_m", m_irr, 2'b01);
    check_eq("post_rst_grant_r", r_irr, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
